// File: rtl/float_unit_arbiter.sv
// Round-robin arbiter that shares one fixed-latency float unit among NUM_REQ lanes,
// tagging each issued operation so its result is routed back to the lane that issued it.
module float_unit_arbiter #(
   parameter  int EXP      = 8,
   parameter  int FRAC     = 23,
   parameter  int NUM_REQ  = 4,
   parameter  int UNIT_LAT = 3,
   parameter  int MAX_OUT  = 2,
   localparam int W        = 1 + EXP + FRAC
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*W-1:0]   req_a,
   input  logic [NUM_REQ*W-1:0]   req_b,
   input  logic [NUM_REQ*2-1:0]   req_op,
   output logic                   unit_valid,
   output logic [W-1:0]           unit_a,
   output logic [W-1:0]           unit_b,
   output logic [1:0]             unit_op,
   input  logic                   unit_res_valid,
   input  logic [W-1:0]           unit_res,
   output logic [NUM_REQ-1:0]     resp_valid,
   output logic [W-1:0]           resp_data,
   output logic                   busy,
   output logic                   tag_error
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_OUT + 1);

   logic [IW-1:0]      ptr;
   logic [CW-1:0]      out_cnt [NUM_REQ];
   logic [NUM_REQ-1:0] elig;
   logic               grant;
   logic [IW-1:0]      gnt_idx;
   logic [IW-1:0]      idx_p0;
   logic               tag_vld_p1 [UNIT_LAT];
   logic [IW-1:0]      tag_idx_p1 [UNIT_LAT];

   function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                              input logic inc, input logic dec);
      cnt_next = cnt;
      if (inc && !dec && cnt < CW'(MAX_OUT))
         cnt_next = cnt + CW'(1);
      else if (dec && !inc && cnt != '0)
         cnt_next = cnt - CW'(1);
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // A lane at its cap whose result is being delivered this cycle frees a slot now,
   // so it may be granted in the same cycle without exceeding MAX_OUT.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         elig[i] = req_valid[i] && !reset &&
                   (out_cnt[i] < CW'(MAX_OUT) || resp_valid[i]);
   end

   always_comb begin
      int            j;
      logic [IW-1:0] cand;
      j       = 0;
      cand    = '0;
      grant   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ)
            j = j - NUM_REQ;
         cand = IW'(j);
         if (!grant && elig[cand]) begin
            grant   = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant)
         req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         busy = busy | (out_cnt[i] != '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr        <= '0;
         unit_valid <= 1'b0;
         unit_a     <= '0;
         unit_b     <= '0;
         unit_op    <= '0;
         idx_p0     <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         tag_error  <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++)
            out_cnt[i] <= '0;
         for (int s = 0; s < UNIT_LAT; s++) begin
            tag_vld_p1[s] <= 1'b0;
            tag_idx_p1[s] <= '0;
         end
      end else begin
         // p0: issue register feeding the shared unit
         unit_valid <= grant;
         if (grant) begin
            ptr     <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
            unit_a  <= req_a[gnt_idx*W +: W];
            unit_b  <= req_b[gnt_idx*W +: W];
            unit_op <= req_op[gnt_idx*2 +: 2];
            idx_p0  <= gnt_idx;
         end

         // p1: tag shift register, last stage aligned with unit_res_valid
         tag_vld_p1[0] <= unit_valid;
         tag_idx_p1[0] <= idx_p0;
         for (int s = 1; s < UNIT_LAT; s++) begin
            tag_vld_p1[s] <= tag_vld_p1[s-1];
            tag_idx_p1[s] <= tag_idx_p1[s-1];
         end

         // p2: response routing
         resp_valid <= '0;
         if (unit_res_valid && tag_vld_p1[UNIT_LAT-1]) begin
            resp_valid <= onehot(tag_idx_p1[UNIT_LAT-1]);
            resp_data  <= unit_res;
         end
         if (unit_res_valid != tag_vld_p1[UNIT_LAT-1])
            tag_error <= 1'b1;

         for (int i = 0; i < NUM_REQ; i++)
            out_cnt[i] <= cnt_next(out_cnt[i], req_ready[i], resp_valid[i]);
      end
   end

endmodule

// File: tb/tb_float_unit_arbiter.sv
// Bench for float_unit_arbiter: fixed-latency unit model, response scoreboard,
// grant-pattern table and hand-written reset / error sequences.
module tb_float_unit_arbiter;

   localparam int EXP = 8, FRAC = 23, NUM_REQ = 4, UNIT_LAT = 3, MAX_OUT = 2;
   localparam int W = 1 + EXP + FRAC;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req_valid, req_ready, resp_valid;
   logic [NUM_REQ*W-1:0] req_a, req_b;
   logic [NUM_REQ*2-1:0] req_op;
   logic                 unit_valid, unit_res_valid, busy, tag_error;
   logic [W-1:0]         unit_a, unit_b, unit_res, resp_data;
   logic [1:0]           unit_op;
   logic                 inj, drop_mode;

   int n_vec = 0, n_err = 0, cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   float_unit_arbiter #(.EXP(EXP), .FRAC(FRAC), .NUM_REQ(NUM_REQ),
                        .UNIT_LAT(UNIT_LAT), .MAX_OUT(MAX_OUT)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .unit_valid(unit_valid),
      .unit_a(unit_a), .unit_b(unit_b), .unit_op(unit_op),
      .unit_res_valid(unit_res_valid), .unit_res(unit_res), .resp_valid(resp_valid),
      .resp_data(resp_data), .busy(busy), .tag_error(tag_error));

   // Stand-in for the float unit: exact for 1.0+2.0, otherwise an operand mix.
   function automatic logic [W-1:0] unit_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
      if (a == 32'h3F800000 && b == 32'h40000000 && op == 2'd0)
         return 32'h40400000;
      return {a[15:0], b[31:16]} ^ {30'd0, op};
   endfunction

   logic         mv    [UNIT_LAT];
   logic         mdrop [UNIT_LAT];
   logic [W-1:0] md    [UNIT_LAT];

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < UNIT_LAT; i++) begin
            mv[i] <= 1'b0; mdrop[i] <= 1'b0; md[i] <= '0;
         end
      end else begin
         mv[0]    <= unit_valid;
         mdrop[0] <= drop_mode;
         md[0]    <= unit_fn(unit_a, unit_b, unit_op);
         for (int i = 1; i < UNIT_LAT; i++) begin
            mv[i] <= mv[i-1]; mdrop[i] <= mdrop[i-1]; md[i] <= md[i-1];
         end
      end
   end

   assign unit_res_valid = (mv[UNIT_LAT-1] & ~mdrop[UNIT_LAT-1]) | inj;
   assign unit_res       = md[UNIT_LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct { int idx; logic [W-1:0] data; int due; logic drop; } sb_t;
   sb_t                sb[$];
   sb_t                e;
   logic               iss_pend = 1'b0;
   logic [W-1:0]       iss_a, iss_b;
   logic [1:0]         iss_op;
   logic [NUM_REQ-1:0] exp_oh;
   int                 gi;

   always @(negedge clock) begin
      if (reset) begin
         sb.delete();
         iss_pend = 1'b0;
      end else begin
         if (iss_pend) begin
            chk("issue_valid", unit_valid, 1);
            chk("issue_a", unit_a, iss_a);
            chk("issue_b", unit_b, iss_b);
            chk("issue_op", unit_op, iss_op);
         end else
            chk("idle_unit_valid", unit_valid, 0);
         if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.drop)
               chk("resp_dropped", resp_valid, 0);
            else begin
               exp_oh = '0;
               exp_oh[e.idx] = 1'b1;
               chk("resp_route", resp_valid, exp_oh);
               chk("resp_data", resp_data, e.data);
            end
         end else
            chk("resp_none", resp_valid, 0);
         iss_pend = 1'b0;
         chk("ready_subset", req_ready & ~req_valid, 0);
         if ((req_valid & req_ready) != 0) begin
            chk("ready_onehot", $countones(req_ready), 1);
            gi = 0;
            for (int k = 0; k < NUM_REQ; k++)
               if (req_ready[k]) gi = k;
            iss_pend = 1'b1;
            iss_a    = req_a[gi*W +: W];
            iss_b    = req_b[gi*W +: W];
            iss_op   = req_op[gi*2 +: 2];
            sb.push_back('{gi, unit_fn(iss_a, iss_b, iss_op), cyc + UNIT_LAT + 2, drop_mode});
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_op[i*2 +: 2] = op;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         req_valid = '0;
         @(negedge clock);
      end
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      req_valid = '0;
      tick();
      reset = 1'b0;
   endtask

   typedef struct { logic [NUM_REQ-1:0] valid; logic [NUM_REQ-1:0] ready; } vec_t;
   vec_t        tbl[$];
   logic [W-1:0] specials [NUM_REQ] = '{32'h7FC00000, 32'h7F800000, 32'h00000001, 32'hFF800000};
   logic [7:0]  cap_pat = 8'b0110_0011;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) tbl.push_back('{4'b1111, 4'(1 << (i % 4))});
      for (int i = 0; i < 6; i++) tbl.push_back('{4'b0000, 4'b0000});
      for (int i = 0; i < 8; i++) tbl.push_back('{4'b0100, cap_pat[i] ? 4'b0100 : 4'b0000});
      for (int i = 0; i < 6; i++) tbl.push_back('{4'b0000, 4'b0000});

      reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
      inj = 1'b0; drop_mode = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_unit_valid", unit_valid, 0);
      chk("rst_unit_a", unit_a, 0);
      chk("rst_unit_b", unit_b, 0);
      chk("rst_unit_op", unit_op, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tag_error", tag_error, 0);

      // single requester, 1.0 + 2.0
      tick();
      req_valid = 4'b0001;
      set_req(0, 32'h3F800000, 32'h40000000, 2'd0);
      @(negedge clock);
      chk("single_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      @(negedge clock);
      chk("single_unit_valid", unit_valid, 1);
      chk("single_unit_a", unit_a, 32'h3F800000);
      chk("single_unit_b", unit_b, 32'h40000000);
      idle(3);
      idle(1);
      chk("single_resp_valid", resp_valid, 4'b0001);
      chk("single_resp_data", resp_data, 32'h40400000);
      idle(1);
      chk("single_busy_after", busy, 0);

      // contention then cap, from pointer 0
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         tick();
         req_valid = tbl[i].valid;
         for (int k = 0; k < NUM_REQ; k++)
            set_req(k, (i % 3 == 0) ? specials[k] : W'($urandom), W'($urandom),
                    2'($urandom_range(0, 3)));
         @(negedge clock);
         chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
      end

      // requester 1 at its cap accepts as an earlier result returns
      for (int k = 0; k < 8; k++) begin
         tick();
         req_valid = (k < 7) ? 4'b0010 : 4'b0000;
         set_req(1, W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
         @(negedge clock);
         if (k < 7)
            chk($sformatf("simul%0d_ready", k), req_ready,
                (k < 2 || k >= 5) ? 4'b0010 : 4'b0000);
         if (k >= 5)
            chk($sformatf("simul%0d_cnt", k), dut.out_cnt[1], MAX_OUT);
      end
      idle(5);
      chk("simul_busy_drained", busy, 0);

      // unexpected result
      tick();
      inj = 1'b1;
      @(negedge clock);
      tick();
      inj = 1'b0;
      @(negedge clock);
      chk("unexp_tag_error", tag_error, 1);
      chk("unexp_no_resp", resp_valid, 0);
      do_reset();
      @(negedge clock);
      chk("unexp_cleared", tag_error, 0);

      // missing result
      drop_mode = 1'b1;
      tick();
      req_valid = 4'b0001;
      set_req(0, 32'h00000001, 32'h7FC00000, 2'd1);
      @(negedge clock);
      chk("miss_ready", req_ready, 4'b0001);
      idle(4);
      idle(1);
      chk("miss_tag_error", tag_error, 1);
      chk("miss_no_resp", resp_valid, 0);
      chk("miss_busy_held", busy, 1);
      drop_mode = 1'b0;
      do_reset();
      @(negedge clock);
      chk("miss_cleared", tag_error, 0);
      chk("miss_busy_cleared", busy, 0);

      // reset with three operations in flight
      for (int k = 0; k < 3; k++) begin
         tick();
         req_valid = 4'(1 << k);
         set_req(k, W'($urandom), W'($urandom), 2'(k));
         @(negedge clock);
         chk($sformatf("mid%0d_ready", k), req_ready, 4'(1 << k));
      end
      tick();
      req_valid = '0;
      reset = 1'b1;
      @(negedge clock);
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("midrst_req_ready", req_ready, 0);
      chk("midrst_unit_valid", unit_valid, 0);
      chk("midrst_unit_a", unit_a, 0);
      chk("midrst_unit_b", unit_b, 0);
      chk("midrst_unit_op", unit_op, 0);
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_resp_data", resp_data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_tag_error", tag_error, 0);
      tick();
      req_valid = 4'b1111;
      for (int k = 0; k < NUM_REQ; k++)
         set_req(k, W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
      @(negedge clock);
      chk("midrst_ptr0_grant", req_ready, 4'b0001);
      idle(4);
      idle(1);
      chk("midrst_fresh_resp", resp_valid, 4'b0001);
      idle(2);
      chk("midrst_tag_error_end", tag_error, 0);

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
